// File: rtl/stamp_conveyor.sv
// Receives per-slot stamp/take events from the pool arbiter, keeps them pending and drains one beat per cycle.
// Define STAMP_CONVEYOR_FIXED_PRIO_EN for lowest-index-first selection instead of round-robin.
module stamp_conveyor #(
    parameter int SLOTS   = 8,
    parameter int STAMP_W = 3,
    parameter int TAKE_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [SLOTS*STAMP_W-1:0]   pool_stamp_flat,
    input  logic [SLOTS-1:0]           pool_stamp_in,
    input  logic [SLOTS*TAKE_W-1:0]    pool_take_flat,
    input  logic [SLOTS-1:0]           pool_take_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_slot,
    output logic [STAMP_W-1:0]         out_stamp,
    output logic                       out_stamp_vld,
    output logic [TAKE_W-1:0]          out_take,
    output logic                       out_take_vld,
    output logic [3:0]                 pend_cnt,
    output logic [SLOTS-1:0]           overflow,
    input  logic                       ovf_clr
);

    logic [SLOTS-1:0]   stamp_pend_q, stamp_pend_d;
    logic [SLOTS-1:0]   take_pend_q,  take_pend_d;
    logic [STAMP_W-1:0] stamp_val_q [SLOTS];
    logic [STAMP_W-1:0] stamp_val_d [SLOTS];
    logic [TAKE_W-1:0]  take_val_q  [SLOTS];
    logic [TAKE_W-1:0]  take_val_d  [SLOTS];

    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_slot_q, out_slot_d;
    logic [STAMP_W-1:0] out_stamp_q, out_stamp_d;
    logic               out_stamp_vld_q, out_stamp_vld_d;
    logic [TAKE_W-1:0]  out_take_q, out_take_d;
    logic               out_take_vld_q, out_take_vld_d;
    logic [3:0]         pend_cnt_q, pend_cnt_d;
    logic [SLOTS-1:0]   overflow_q, overflow_d;
    logic [2:0]         ptr_q, ptr_d;

    logic [SLOTS-1:0]   eligible;
    logic [SLOTS-1:0]   new_ovf;
    logic               load_en;
    logic               found;
    logic [2:0]         sel;
    logic [2:0]         idx;

    // Pick the first slot with anything pending, starting at the round-robin pointer.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        eligible = stamp_pend_q | take_pend_q;
        found    = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int k = 0; k < SLOTS; k++) begin
`ifdef STAMP_CONVEYOR_FIXED_PRIO_EN
            idx = 3'(k);
`else
            idx = ptr_q + 3'(k);
`endif
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        stamp_pend_d    = stamp_pend_q;
        take_pend_d     = take_pend_q;
        stamp_val_d     = stamp_val_q;
        take_val_d      = take_val_q;
        out_valid_d     = out_valid_q;
        out_slot_d      = out_slot_q;
        out_stamp_d     = out_stamp_q;
        out_stamp_vld_d = out_stamp_vld_q;
        out_take_d      = out_take_q;
        out_take_vld_d  = out_take_vld_q;
        ptr_d           = ptr_q;
        new_ovf         = '0;
        load_en         = !out_valid_q || out_ready;

        if (flush) begin
            stamp_pend_d    = '0;
            take_pend_d     = '0;
            out_valid_d     = 1'b0;
            out_stamp_vld_d = 1'b0;
            out_take_vld_d  = 1'b0;
            ptr_d           = '0;
        end else begin
            if (load_en) begin
                if (found) begin
                    out_valid_d       = 1'b1;
                    out_slot_d        = sel;
                    out_stamp_d       = stamp_val_q[sel];
                    out_stamp_vld_d   = stamp_pend_q[sel];
                    out_take_d        = take_val_q[sel];
                    out_take_vld_d    = take_pend_q[sel];
                    stamp_pend_d[sel] = 1'b0;
                    take_pend_d[sel]  = 1'b0;
`ifdef STAMP_CONVEYOR_FIXED_PRIO_EN
                    ptr_d = '0;
`else
                    ptr_d = sel + 3'd1;
`endif
                end else begin
                    out_valid_d     = 1'b0;
                    out_stamp_vld_d = 1'b0;
                    out_take_vld_d  = 1'b0;
                end
            end
            // Arrivals see pend bits after the load clear, so a slot leaving this edge never flags overflow.
            for (int i = 0; i < SLOTS; i++) begin
                if (pool_stamp_in[i]) begin
                    if (stamp_pend_d[i]) new_ovf[i] = 1'b1;
                    stamp_pend_d[i] = 1'b1;
                    stamp_val_d[i]  = pool_stamp_flat[i*STAMP_W +: STAMP_W];
                end
                if (pool_take_in[i]) begin
                    if (take_pend_d[i]) new_ovf[i] = 1'b1;
                    take_pend_d[i] = 1'b1;
                    take_val_d[i]  = pool_take_flat[i*TAKE_W +: TAKE_W];
                end
            end
        end

        overflow_d = (ovf_clr ? '0 : overflow_q) | new_ovf;
        pend_cnt_d = 4'($countones(stamp_pend_d | take_pend_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_pend_q    <= '0;
            take_pend_q     <= '0;
            // NOTE: the per-slot value store is reset too, so no beat can ever carry X after reset.
            for (int i = 0; i < SLOTS; i++) begin
                stamp_val_q[i] <= '0;
                take_val_q[i]  <= '0;
            end
            out_valid_q     <= 1'b0;
            out_slot_q      <= '0;
            out_stamp_q     <= '0;
            out_stamp_vld_q <= 1'b0;
            out_take_q      <= '0;
            out_take_vld_q  <= 1'b0;
            pend_cnt_q      <= '0;
            overflow_q      <= '0;
            ptr_q           <= '0;
        end else begin
            stamp_pend_q    <= stamp_pend_d;
            take_pend_q     <= take_pend_d;
            stamp_val_q     <= stamp_val_d;
            take_val_q      <= take_val_d;
            out_valid_q     <= out_valid_d;
            out_slot_q      <= out_slot_d;
            out_stamp_q     <= out_stamp_d;
            out_stamp_vld_q <= out_stamp_vld_d;
            out_take_q      <= out_take_d;
            out_take_vld_q  <= out_take_vld_d;
            pend_cnt_q      <= pend_cnt_d;
            overflow_q      <= overflow_d;
            ptr_q           <= ptr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_slot      = out_slot_q;
    assign out_stamp     = out_stamp_q;
    assign out_stamp_vld = out_stamp_vld_q;
    assign out_take      = out_take_q;
    assign out_take_vld  = out_take_vld_q;
    assign pend_cnt      = pend_cnt_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_stamp_conveyor.sv
// Directed bench for stamp_conveyor: expected beats are queued as events are driven and checked as they drain.
module tb_stamp_conveyor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [23:0] pool_stamp_flat;
    logic [7:0]  pool_stamp_in;
    logic [39:0] pool_take_flat;
    logic [7:0]  pool_take_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_slot;
    logic [2:0]  out_stamp;
    logic        out_stamp_vld;
    logic [4:0]  out_take;
    logic        out_take_vld;
    logic [3:0]  pend_cnt;
    logic [7:0]  overflow;
    logic        ovf_clr;

    stamp_conveyor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .pool_stamp_flat (pool_stamp_flat),
        .pool_stamp_in   (pool_stamp_in),
        .pool_take_flat  (pool_take_flat),
        .pool_take_in    (pool_take_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_slot        (out_slot),
        .out_stamp       (out_stamp),
        .out_stamp_vld   (out_stamp_vld),
        .out_take        (out_take),
        .out_take_vld    (out_take_vld),
        .pend_cnt        (pend_cnt),
        .overflow        (overflow),
        .ovf_clr         (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] slot;
        logic [2:0] stamp;
        logic       svld;
        logic [4:0] take;
        logic       tvld;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        pool_stamp_in = '0;
        pool_take_in  = '0;
        flush         = 1'b0;
        ovf_clr       = 1'b0;
    endtask

    task automatic drive(input int slot, input logic s_en, input logic [2:0] s,
                         input logic t_en, input logic [4:0] t, input logic push);
        beat_t b;
        if (s_en) begin
            pool_stamp_flat[slot*3 +: 3] = s;
            pool_stamp_in[slot]          = 1'b1;
        end
        if (t_en) begin
            pool_take_flat[slot*5 +: 5] = t;
            pool_take_in[slot]          = 1'b1;
        end
        if (push) begin
            b.slot  = 3'(slot);
            b.stamp = s;
            b.svld  = s_en;
            b.take  = t;
            b.tvld  = t_en;
            exp_q.push_back(b);
        end
    endtask

    // Compare the presented beat with the head of the scoreboard without consuming it.
    task automatic check_front(input string tag);
        beat_t b;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fails++;
            $error("FAIL %s: beat observed with no expected beat queued", tag);
        end
        if (exp_q.size() != 0) begin
            b = exp_q[0];
            check({tag, " valid"}, out_valid, 1);
            check({tag, " slot"}, out_slot, b.slot);
            check({tag, " stamp_vld"}, out_stamp_vld, b.svld);
            check({tag, " take_vld"}, out_take_vld, b.tvld);
            if (b.svld) check({tag, " stamp"}, out_stamp, b.stamp);
            if (b.tvld) check({tag, " take"}, out_take, b.take);
        end
    endtask

    task automatic pop_beat(input string tag);
        check_front(tag);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic drain_all(input string tag, input int budget);
        int waited = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && waited < budget) begin
            if (out_valid) pop_beat(tag);
            tick();
            waited++;
        end
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fails++;
            $error("FAIL %s drain: %0d beats still expected after %0d cycles", tag, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            pool_stamp_flat = 24'($urandom);
            pool_stamp_in   = 8'($urandom);
            pool_take_flat  = {8'($urandom), 32'($urandom)};
            pool_take_in    = 8'($urandom);
            out_ready       = 1'($urandom);
            flush           = 1'($urandom);
            ovf_clr         = 1'($urandom);
            tick();
        end
        check("rst out_valid", out_valid, 0);
        check("rst out_slot", out_slot, 0);
        check("rst out_stamp", out_stamp, 0);
        check("rst out_stamp_vld", out_stamp_vld, 0);
        check("rst out_take", out_take, 0);
        check("rst out_take_vld", out_take_vld, 0);
        check("rst pend_cnt", pend_cnt, 0);
        check("rst overflow", overflow, 0);
        pool_stamp_flat = '0;
        pool_take_flat  = '0;
        out_ready       = 1'b1;
        clear_in();
        rst_n = 1'b1;
        tick();
        check("post-rst out_valid", out_valid, 0);
        check("post-rst pend_cnt", pend_cnt, 0);

        // Single event on slot 2.
        pool_stamp_flat = 24'h000140;
        pool_take_flat  = 40'h0000004C00;
        pool_stamp_in   = 8'h04;
        pool_take_in    = 8'h04;
        exp_q.push_back('{slot: 3'd2, stamp: 3'd5, svld: 1'b1, take: 5'h13, tvld: 1'b1});
        tick();
        clear_in();
        check("single pend_cnt", pend_cnt, 1);
        check("single early valid", out_valid, 0);
        tick();
        pop_beat("single");
        check("single pend_cnt after load", pend_cnt, 0);
        tick();
        check("single idle valid", out_valid, 0);
        check("single idle stamp_vld", out_stamp_vld, 0);
        check("single idle take_vld", out_take_vld, 0);
        check("single idle slot hold", out_slot, 2);

        // Flush returns the pointer to 0 before the burst.
        flush = 1'b1;
        tick();
        clear_in();
        check("pre-burst pend_cnt", pend_cnt, 0);

        // Full stamp burst, ready high.
        for (int i = 0; i < 8; i++) drive(i, 1'b1, 3'(7 - i), 1'b0, 5'd0, 1'b1);
        tick();
        clear_in();
        check("burst pend_cnt full", pend_cnt, 8);
        check("burst early valid", out_valid, 0);
        for (int b = 0; b < 8; b++) begin
            tick();
            pop_beat("burst");
            check("burst pend_cnt", pend_cnt, 64'(7 - b));
        end
        tick();
        check("burst end valid", out_valid, 0);

        // Backpressure: same burst with stamps and some takes, ready low for 5 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(i, 1'b1, 3'(i), 1'(8'hA5 >> i), 5'(i * 3 + 1), 1'b1);
        tick();
        clear_in();
        tick();
        for (int c = 0; c < 5; c++) begin
            check_front("bp hold");
            check("bp pend_cnt", pend_cnt, 7);
            tick();
        end
        drain_all("bp", 20);

        // Overflow on slot 3 while slot 0 is held; then set-wins against ovf_clr on slot 6.
        out_ready = 1'b0;
        drive(0, 1'b1, 3'd2, 1'b0, 5'd0, 1'b1);
        tick();
        clear_in();
        drive(3, 1'b1, 3'd1, 1'b0, 5'd0, 1'b0);
        tick();
        clear_in();
        drive(3, 1'b1, 3'd6, 1'b0, 5'd0, 1'b1);
        tick();
        clear_in();
        check("ovf slot3", overflow, 8'h08);
        check_front("ovf hold");
        drive(6, 1'b1, 3'd4, 1'b0, 5'd0, 1'b0);
        tick();
        clear_in();
        drive(6, 1'b1, 3'd5, 1'b0, 5'd0, 1'b1);
        ovf_clr = 1'b1;
        tick();
        clear_in();
        check("ovf clr vs set", overflow, 8'h40);
        drain_all("ovf", 20);
        ovf_clr = 1'b1;
        tick();
        clear_in();
        check("ovf cleared", overflow, 8'h00);

        // Arrival on the slot being loaded: old value leaves, new one stays pending.
        out_ready = 1'b1;
        drive(2, 1'b1, 3'd1, 1'b0, 5'd0, 1'b1);
        tick();
        clear_in();
        drive(2, 1'b1, 3'd7, 1'b0, 5'd0, 1'b1);
        tick();
        clear_in();
        pop_beat("same-edge old");
        check("same-edge pend_cnt", pend_cnt, 1);
        check("same-edge no ovf", overflow, 8'h00);
        tick();
        pop_beat("same-edge new");
        tick();
        check("same-edge idle valid", out_valid, 0);

        // Flush mid-burst, then pointer must restart at 0.
        flush = 1'b1;
        tick();
        clear_in();
        for (int i = 0; i < 8; i++) drive(i, 1'b1, 3'(i ^ 5), 1'b0, 5'd0, i < 5);
        tick();
        clear_in();
        for (int b = 0; b < 5; b++) begin
            tick();
            pop_beat("flush burst");
        end
        check("flush pre pend_cnt", pend_cnt, 3);
        flush = 1'b1;
        tick();
        clear_in();
        check("flush valid", out_valid, 0);
        check("flush pend_cnt", pend_cnt, 0);
        check("flush stamp_vld", out_stamp_vld, 0);
        drive(1, 1'b1, 3'd2, 1'b1, 5'd9, 1'b1);
        drive(6, 1'b1, 3'd3, 1'b0, 5'd0, 1'b1);
        tick();
        clear_in();
        drain_all("post flush", 10);

        // Reset asserted while a beat is held.
        out_ready = 1'b0;
        drive(0, 1'b1, 3'd4, 1'b0, 5'd0, 1'b0);
        drive(7, 1'b1, 3'd2, 1'b0, 5'd0, 1'b0);
        tick();
        clear_in();
        tick();
        check("mid-drain valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", out_valid, 0);
        check("async rst pend_cnt", pend_cnt, 0);
        check("async rst stamp", out_stamp, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("after async rst valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
